// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - MDUOP operation codes (also decoded by the control unit)
//   - ReadHILO select codes for the mfhi/mflo read path
//   - default busy latencies handed to the unit through Time
//   - FSM state type and an operation classifier
package mdu_pkg;

   localparam logic [3:0] MDU_NOP   = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MTHI  = 4'd5;
   localparam logic [3:0] MDU_MTLO  = 4'd6;

   localparam logic [1:0] HILO_NONE = 2'd0;
   localparam logic [1:0] HILO_HI   = 2'd1;
   localparam logic [1:0] HILO_LO   = 2'd2;

   localparam logic [3:0] MULT_TIME = 4'd5;
   localparam logic [3:0] DIV_TIME  = 4'd10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

   // True for the four operations that produce a {HI,LO} result pair.
   function automatic logic is_md_op(input logic [3:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU) ||
             (op == MDU_DIV)  || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: E-stage connection between the control/forwarding side and the MDU.
//   Start, MDUOP, Time : operation request from the control unit
//   A, B               : forwarded rs/rt operands
//   ReadHILO           : mfhi/mflo read select
//   Busy               : operation in flight (to the hazard unit)
//   HI, LO             : architectural HI/LO registers
//   HILOOut            : selected HI/LO read value for the E-stage result mux
// master = control/datapath side, slave = mdu_core.
interface mdu_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic [3:0]       MDUOP;
   logic [3:0]       Time;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [1:0]       ReadHILO;
   logic             Busy;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;
   logic [WIDTH-1:0] HILOOut;

   modport master (
      output Start, MDUOP, Time, A, B, ReadHILO,
      input  Busy, HI, LO, HILOOut
   );

   modport slave (
      input  Start, MDUOP, Time, A, B, ReadHILO,
      output Busy, HI, LO, HILOOut
   );
endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: combinational result generator for MULT/MULTU/DIV/DIVU.
//   op_i       : MDUOP code
//   a_i, b_i   : rs/rt operands
//   hi_o, lo_o : result pair destined for HI/LO
//   we_o       : result may be committed (low for divide by zero and
//                for non-arithmetic codes)
module mdu_arith
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             we_o
);
   logic signed [WIDTH-1:0]   a_s;
   logic signed [WIDTH-1:0]   b_s;
   logic signed [2*WIDTH-1:0] a_x;
   logic signed [2*WIDTH-1:0] b_x;
   logic signed [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0]        prod_u;
   logic signed [WIDTH-1:0]   quot_s;
   logic signed [WIDTH-1:0]   rem_s;
   logic [WIDTH-1:0]          quot_u;
   logic [WIDTH-1:0]          rem_u;
   logic                      b_zero;
   logic                      div_ovf;

   assign a_s = a_i;
   assign b_s = b_i;

   // Explicit sign extension to full product width; the low 2*WIDTH bits
   // of the extended product are the exact signed product.
   assign a_x    = {{WIDTH{a_i[WIDTH-1]}}, a_i};
   assign b_x    = {{WIDTH{b_i[WIDTH-1]}}, b_i};
   assign prod_s = a_x * b_x;
   assign prod_u = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

   assign b_zero  = (b_i == '0);
   // Most-negative / -1 does not fit; the defined answer is quotient = dividend, remainder 0.
   assign div_ovf = (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == '1);

   always_comb begin
      quot_s = '0;
      rem_s  = '0;
      quot_u = '0;
      rem_u  = '0;
      if (!b_zero) begin
         quot_u = a_i / b_i;
         rem_u  = a_i % b_i;
         if (div_ovf) begin
            quot_s = a_s;
            rem_s  = '0;
         end else begin
            // Signed / truncates toward zero and % takes the dividend's sign.
            quot_s = a_s / b_s;
            rem_s  = a_s % b_s;
         end
      end
   end

   always_comb begin
      hi_o = '0;
      lo_o = '0;
      we_o = 1'b0;
      case (op_i)
         MDU_MULT: begin
            {hi_o, lo_o} = prod_s;
            we_o         = 1'b1;
         end
         MDU_MULTU: begin
            {hi_o, lo_o} = prod_u;
            we_o         = 1'b1;
         end
         MDU_DIV: begin
            hi_o = rem_s;
            lo_o = quot_s;
            we_o = !b_zero;
         end
         MDU_DIVU: begin
            hi_o = rem_u;
            lo_o = quot_u;
            we_o = !b_zero;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu_core.sv
// mdu_core: E-stage multiply/divide unit owning HI and LO.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : mdu_if slave -- Start/MDUOP/Time/A/B/ReadHILO in,
//           Busy/HI/LO/HILOOut out
// The result is computed at the accept edge and held pending; it is
// written to HI/LO once the Time-cycle busy window has elapsed.
module mdu_core
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic clk,
   input  logic reset,
   mdu_if.slave bus
);
   mdu_state_e       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] phi_q, phi_d;
   logic [WIDTH-1:0] plo_q, plo_d;
   logic             pwe_q, pwe_d;

   logic [WIDTH-1:0] ar_hi;
   logic [WIDTH-1:0] ar_lo;
   logic             ar_we;
   logic             accept;

   mdu_arith #(.WIDTH(WIDTH)) u_arith (
      .op_i (bus.MDUOP),
      .a_i  (bus.A),
      .b_i  (bus.B),
      .hi_o (ar_hi),
      .lo_o (ar_lo),
      .we_o (ar_we)
   );

   // Requests arriving while RUN are dropped, not queued.
   assign accept = bus.Start && (state_q == ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         phi_q   <= '0;
         plo_q   <= '0;
         pwe_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         phi_q   <= phi_d;
         plo_q   <= plo_d;
         pwe_q   <= pwe_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      phi_d   = phi_q;
      plo_d   = plo_q;
      pwe_d   = pwe_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (is_md_op(bus.MDUOP)) begin
                  phi_d = ar_hi;
                  plo_d = ar_lo;
                  pwe_d = ar_we;
                  cnt_d = bus.Time;
                  if (bus.Time == 4'd0) begin
                     // Zero latency: commit straight away, never raise Busy.
                     if (ar_we) begin
                        hi_d = ar_hi;
                        lo_d = ar_lo;
                     end
                  end else begin
                     state_d = ST_RUN;
                  end
               end else if (bus.MDUOP == MDU_MTHI) begin
                  hi_d = bus.A;
               end else if (bus.MDUOP == MDU_MTLO) begin
                  lo_d = bus.A;
               end
            end
         end
         ST_RUN: begin
            if (cnt_q <= 4'd1) begin
               // Divide by zero leaves pwe_q low, so HI/LO keep their values.
               if (pwe_q) begin
                  hi_d = phi_q;
                  lo_d = plo_q;
               end
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.Busy = (state_q == ST_RUN);
      bus.HI   = hi_q;
      bus.LO   = lo_q;
      case (bus.ReadHILO)
         HILO_HI:   bus.HILOOut = hi_q;
         HILO_LO:   bus.HILOOut = lo_q;
         HILO_NONE: bus.HILOOut = '0;
         default:   bus.HILOOut = '0;
      endcase
   end

endmodule

// File: tb/tb_mdu_core.sv
// tb_mdu_core: directed stimulus for mdu_core with a queue-based scoreboard.
// The stimulus process pushes the expected busy length and HI/LO/HILOOut
// for every operation it issues; the monitor detects each accepted
// operation from the bus, measures the Busy window and compares.
module tb_mdu_core;
   import mdu_pkg::*;

   typedef struct {
      string       name;
      int          busy;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] out;
   } exp_t;

   logic clk;
   logic reset;
   logic allow_busy_start;
   int   checks;
   int   errors;
   exp_t sb_q[$];

   mdu_if #(.WIDTH(32)) bus ();

   mdu_core #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   task automatic expect_op(input string name, input int busy, input logic [31:0] hi,
                            input logic [31:0] lo, input logic [31:0] out);
      exp_t e;
      e.name = name;
      e.busy = busy;
      e.hi   = hi;
      e.lo   = lo;
      e.out  = out;
      sb_q.push_back(e);
   endtask

   // Called just after a rising edge; leaves Start high for one edge.
   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t, input logic [1:0] rd);
      bus.Start    = 1'b1;
      bus.MDUOP    = op;
      bus.A        = a;
      bus.B        = b;
      bus.Time     = t;
      bus.ReadHILO = rd;
      @(posedge clk); #1;
      bus.Start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40 && bus.Busy; i++) begin
         @(posedge clk); #1;
      end
      repeat (2) begin
         @(posedge clk); #1;
      end
   endtask

   // The hazard unit must never issue Start while Busy, except where the
   // stimulus deliberately does so to show the request is dropped.
   always @(negedge clk) begin
      if (!reset && bus.Start && bus.Busy) begin
         checks++;
         if (!allow_busy_start) begin
            errors++;
            $display("FAIL issue_while_busy: Start=1 seen with Busy=1 op=%0d", bus.MDUOP);
         end
      end
   end

   // Monitor: an operation is accepted at the edge following a negedge
   // where Start=1, Busy=0 and MDUOP is a defined non-NOP code.
   initial begin : monitor
      exp_t e;
      int   n;
      @(negedge clk);
      forever begin
         if (!reset && bus.Start && !bus.Busy && bus.MDUOP >= MDU_MULT && bus.MDUOP <= MDU_MTLO) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_empty: accepted op=%0d with no expectation queued", bus.MDUOP);
               @(negedge clk);
            end else begin
               e = sb_q.pop_front();
               @(negedge clk);
               n = 0;
               while (bus.Busy && n < 40) begin
                  n++;
                  @(negedge clk);
               end
               chk({e.name, "_busy"}, 32'(n), 32'(e.busy));
               chk({e.name, "_hi"}, bus.HI, e.hi);
               chk({e.name, "_lo"}, bus.LO, e.lo);
               chk({e.name, "_out"}, bus.HILOOut, e.out);
            end
         end else begin
            @(negedge clk);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      checks           = 0;
      errors           = 0;
      allow_busy_start = 1'b0;
      reset            = 1'b1;
      bus.Start        = 1'b0;
      bus.MDUOP        = MDU_NOP;
      bus.Time         = 4'd0;
      bus.A            = '0;
      bus.B            = '0;
      bus.ReadHILO     = HILO_NONE;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      chk("rst_busy", 32'(bus.Busy), 32'd0);
      chk("rst_hi", bus.HI, 32'h0);
      chk("rst_lo", bus.LO, 32'h0);
      chk("rst_out", bus.HILOOut, 32'h0);

      expect_op("mult_neg", 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'hFFFF_FFF1);
      drive(MDU_MULT, 32'hFFFF_FFFD, 32'd5, MULT_TIME, HILO_LO);
      wait_idle();

      expect_op("divu_7_2", 10, 32'd1, 32'd3, 32'd1);
      drive(MDU_DIVU, 32'd7, 32'd2, DIV_TIME, HILO_HI);
      wait_idle();

      expect_op("div_m7_2", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFD);
      drive(MDU_DIV, 32'hFFFF_FFF9, 32'd2, DIV_TIME, HILO_LO);
      wait_idle();

      expect_op("multu_max", 5, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFE);
      drive(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_TIME, HILO_HI);
      wait_idle();

      expect_op("mult_t0", 0, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001);
      drive(MDU_MULT, 32'h0001_0000, 32'h0001_0000, 4'd0, HILO_HI);
      wait_idle();

      expect_op("div_ovf", 10, 32'h0, 32'h8000_0000, 32'h8000_0000);
      drive(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_TIME, HILO_LO);
      wait_idle();

      expect_op("mthi", 0, 32'h11, 32'h8000_0000, 32'h11);
      drive(MDU_MTHI, 32'h11, 32'h0, 4'd0, HILO_HI);
      wait_idle();

      expect_op("mtlo", 0, 32'h11, 32'h22, 32'h22);
      drive(MDU_MTLO, 32'h22, 32'h0, 4'd0, HILO_LO);
      wait_idle();

      expect_op("div_by0", 10, 32'h11, 32'h22, 32'h11);
      drive(MDU_DIV, 32'd5, 32'd0, DIV_TIME, HILO_HI);
      wait_idle();

      expect_op("divu_by0", 3, 32'h11, 32'h22, 32'h22);
      drive(MDU_DIVU, 32'd9, 32'd0, 4'd3, HILO_LO);
      wait_idle();

      // MTHI pulsed in the second RUN cycle must be dropped.
      expect_op("mult_ign", 5, 32'h0, 32'd42, 32'h0);
      drive(MDU_MULT, 32'd6, 32'd7, MULT_TIME, HILO_NONE);
      @(posedge clk); #1;
      allow_busy_start = 1'b1;
      bus.Start        = 1'b1;
      bus.MDUOP        = MDU_MTHI;
      bus.A            = 32'h0000_DEAD;
      @(posedge clk); #1;
      bus.Start        = 1'b0;
      allow_busy_start = 1'b0;
      wait_idle();

      // MTLO held from inside the RUN window: taken only after Busy=0 is sampled.
      expect_op("mult_hold", 5, 32'hFFFF_FFFF, 32'hFFFF_F830, 32'h0);
      expect_op("mtlo_held", 0, 32'hFFFF_FFFF, 32'h55, 32'h0);
      drive(MDU_MULT, 32'd1000, 32'hFFFF_FFFE, MULT_TIME, 2'd3);
      allow_busy_start = 1'b1;
      bus.Start        = 1'b1;
      bus.MDUOP        = MDU_MTLO;
      bus.A            = 32'h55;
      begin
         logic b;
         int   k;
         k = 0;
         do begin
            @(negedge clk);
            b = bus.Busy;
            @(posedge clk); #1;
            k++;
         end while (b && k < 40);
      end
      bus.Start        = 1'b0;
      allow_busy_start = 1'b0;
      wait_idle();

      // Reset in the third busy cycle of a DIV aborts it.
      expect_op("div_abort", 3, 32'h0, 32'h0, 32'h0);
      drive(MDU_DIV, 32'd100, 32'd7, DIV_TIME, HILO_LO);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_busy_now", 32'(bus.Busy), 32'd0);
      repeat (12) begin
         @(posedge clk); #1;
      end
      chk("abort_busy_late", 32'(bus.Busy), 32'd0);
      chk("abort_hi_late", bus.HI, 32'h0);
      chk("abort_lo_late", bus.LO, 32'h0);

      // Undefined opcode behaves as NOP.
      drive(4'd7, 32'h99, 32'd1, MULT_TIME, HILO_HI);
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("op7_busy", 32'(bus.Busy), 32'd0);
      chk("op7_hi", bus.HI, 32'h0);
      chk("op7_lo", bus.LO, 32'h0);

      for (int i = 0; i < 100 && sb_q.size() > 0; i++) begin
         @(posedge clk); #1;
      end
      chk("sb_drain", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
